// File: rtl/fp32_pkg.sv
// Shared IEEE754 single-precision definitions for the float front ends and the
// sample feeder state encoding.
package fp32_pkg;

    localparam int unsigned FP32_BIAS  = 127;
    localparam int unsigned FP32_EXP_W = 8;
    localparam int unsigned FP32_MAN_W = 23;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    typedef struct packed {
        logic                  sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [FP32_MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StSetup,
        StHigh,
        StLow
    } feeder_state_t;

endpackage

// File: rtl/int_to_fp32.sv
// Combinational signed fixed-point to fp32 converter. Exact for IN_W <= 24,
// so no rounding logic is needed.
module int_to_fp32
    import fp32_pkg::*;
#(
    parameter int unsigned IN_W      = 16,
    parameter int unsigned FRAC_BITS = 0
) (
    input  logic [IN_W-1:0] sample,
    output fp32_t           result
);

    localparam int unsigned P_W = $clog2(IN_W);

    logic            sign;
    logic [IN_W-1:0] mag;
    logic [P_W-1:0]  lead;
    logic [IN_W-2:0] frac;

    always_comb begin
        sign = sample[IN_W-1];
        // Unsigned view keeps the most negative input representable as 2^(IN_W-1).
        mag  = sign ? (~sample + 1'b1) : sample;

        lead = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (mag[i]) begin
                lead = P_W'(i);
            end
        end

        // Normalise so the leading one falls off the top; the rest is the fraction.
        frac = (IN_W-1)'(mag << (P_W'(IN_W - 1) - lead));

        result      = '0;
        if (mag != '0) begin
            result.sign = sign;
            result.exp  = FP32_EXP_W'(FP32_BIAS + 32'(lead) - FRAC_BITS);
            result.man  = FP32_MAN_W'(frac) << (FP32_MAN_W - (IN_W - 1));
        end
    end

endmodule

// File: rtl/sample_to_float_feeder.sv
// Accepts fixed-point samples, converts them to fp32 and emits a clean dataIn
// strobe with data held stable around the rising edge; counts issued strobes.
module sample_to_float_feeder
    import fp32_pkg::*;
#(
    parameter int unsigned IN_W      = 16,
    parameter int unsigned FRAC_BITS = 0,
    parameter int unsigned SETUP     = 1,
    parameter int unsigned STROBE_HI = 2,
    parameter int unsigned STROBE_LO = 2,
    parameter int unsigned SIZE      = 28
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_sample,
    output logic [31:0]             data,
    output logic                    dataIn,
    output logic                    busy,
    output logic [$clog2(SIZE)-1:0] sample_cnt,
    output logic                    window_full
);

    localparam int unsigned PH_MAX_SH = (SETUP > STROBE_HI) ? SETUP : STROBE_HI;
    localparam int unsigned PH_MAX    = (PH_MAX_SH > STROBE_LO) ? PH_MAX_SH : STROBE_LO;
    localparam int unsigned PH_W      = $clog2(PH_MAX + 1);
    localparam int unsigned CNT_W     = $clog2(SIZE);

    feeder_state_t   state_q;
    logic [PH_W-1:0] phase_q;
    logic [IN_W-1:0] sample_q;
    fp32_t           conv;

    int_to_fp32 #(
        .IN_W      (IN_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_conv (
        .sample (sample_q),
        .result (conv)
    );

    // Gated by rstn so the handshake is closed for the whole reset interval.
    assign in_ready = rstn && (state_q == StIdle);
    assign busy     = (state_q != StIdle);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            sample_q    <= '0;
            data        <= FP32_ZERO;
            dataIn      <= 1'b0;
            sample_cnt  <= '0;
            window_full <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        sample_q <= in_sample;
                        state_q  <= StConv;
                    end
                end
                StConv: begin
                    data    <= conv;
                    phase_q <= '0;
                    state_q <= StSetup;
                end
                StSetup: begin
                    if (phase_q == PH_W'(SETUP - 1)) begin
                        phase_q <= '0;
                        dataIn  <= 1'b1;
                        state_q <= StHigh;
                        if (sample_cnt == CNT_W'(SIZE - 1)) begin
                            sample_cnt  <= '0;
                            window_full <= 1'b1;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                StHigh: begin
                    if (phase_q == PH_W'(STROBE_HI - 1)) begin
                        phase_q <= '0;
                        dataIn  <= 1'b0;
                        state_q <= StLow;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                StLow: begin
                    if (phase_q == PH_W'(STROBE_LO - 1)) begin
                        phase_q <= '0;
                        state_q <= StIdle;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_to_float_feeder.sv
// Bench for sample_to_float_feeder: timeline model with real-valued reference
// conversion, per-cycle compare, and literal checks on known samples.
module tb_sample_to_float_feeder;

    localparam int SIZE    = 28;
    localparam int SETUP   = 1;
    localparam int HI      = 2;
    localparam int LO      = 2;
    localparam int CONV_K  = 1;
    localparam int RISE_K  = 1 + SETUP;
    localparam int FALL_K  = RISE_K + HI;
    localparam int IDLE_K  = FALL_K + LO;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_sample = '0;
    logic        in_ready;
    logic [31:0] data;
    logic        dataIn;
    logic        busy;
    logic [4:0]  sample_cnt;
    logic        window_full;

    logic        in_valid2 = 1'b0;
    logic [15:0] in_sample2 = '0;
    logic        in_ready2;
    logic [31:0] data2;
    logic        dataIn2;
    logic        busy2;
    logic [4:0]  sample_cnt2;
    logic        window_full2;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sample_to_float_feeder dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sample   (in_sample),
        .data        (data),
        .dataIn      (dataIn),
        .busy        (busy),
        .sample_cnt  (sample_cnt),
        .window_full (window_full)
    );

    sample_to_float_feeder #(
        .FRAC_BITS (15)
    ) dut_frac (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid2),
        .in_ready    (in_ready2),
        .in_sample   (in_sample2),
        .data        (data2),
        .dataIn      (dataIn2),
        .busy        (busy2),
        .sample_cnt  (sample_cnt2),
        .window_full (window_full2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference: exact value as a real, repacked from double to single.
    function automatic logic [31:0] ref_bits(input int s);
        logic [63:0] b;
        logic [10:0] de;
        if (s == 0) return 32'h0;
        b  = $realtobits(real'(s));
        de = b[62:52] - 11'd896;
        return {b[63], de[7:0], b[51:29]};
    endfunction

    // Timeline model: k counts edges since the accepting edge.
    bit                 m_active = 1'b0;
    int                 m_k = 0;
    logic signed [15:0] m_cur = '0;
    logic [31:0]        m_data = '0;
    int                 m_cnt = 0;
    int                 m_total = 0;
    int                 m_acc = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_data   <= '0;
            m_cnt    <= 0;
            m_total  <= 0;
        end else if (!m_active) begin
            if (in_valid) begin
                m_active <= 1'b1;
                m_k      <= 0;
                m_cur    <= in_sample;
                m_acc    <= m_acc + 1;
            end
        end else begin
            m_k <= m_k + 1;
            if (m_k + 1 == CONV_K) m_data <= ref_bits(int'(m_cur));
            if (m_k + 1 == RISE_K) begin
                m_total <= m_total + 1;
                m_cnt   <= (m_cnt + 1) % SIZE;
            end
            if (m_k + 1 == IDLE_K) m_active <= 1'b0;
        end
    end

    logic exp_din;
    assign exp_din = m_active && (m_k >= RISE_K) && (m_k < FALL_K);

    logic        prev_din = 1'b0;
    logic        prev_din2 = 1'b0;
    logic [31:0] d_pre = '0;
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    always @(negedge clk) begin
        chk("in_ready", in_ready, rstn && !m_active);
        chk("busy", busy, m_active);
        chk("dataIn", dataIn, exp_din);
        chk("data", data, m_data);
        chk("sample_cnt", sample_cnt, m_cnt);
        chk("window_full", window_full, m_total >= SIZE);
        if (m_active && m_k == RISE_K - 1) d_pre <= data;
        if (exp_din) chk("data_stable", data, d_pre);
        if (exp_din && m_k == RISE_K) begin
            if (m_total == 27) begin
                chk("strobe27_full", window_full, 0);
                chk("strobe27_cnt", sample_cnt, 27);
            end
            if (m_total == 28) begin
                chk("strobe28_full", window_full, 1);
                chk("strobe28_cnt", sample_cnt, 0);
            end
            if (m_total == 29) begin
                chk("strobe29_full", window_full, 1);
                chk("strobe29_cnt", sample_cnt, 1);
            end
        end
        if (dataIn && !prev_din) q1.push_back(data);
        if (dataIn2 && !prev_din2) q2.push_back(data2);
        prev_din  <= dataIn;
        prev_din2 <= dataIn2;
    end

    // Presents s and holds in_valid until the model sees it accepted.
    task automatic send(input logic [15:0] s);
        int n0;
        n0        = m_acc;
        in_valid  = 1'b1;
        in_sample = s;
        for (int i = 0; i < 30 && m_acc == n0; i++) begin
            @(posedge clk);
            #1;
        end
        if (m_acc == n0) timeout("accept");
        else chk("accept_busy", busy, 1);
    endtask

    task automatic wait_high();
        for (int i = 0; i < 30 && !(m_active && m_k == RISE_K); i++) begin
            @(posedge clk);
            #1;
        end
        if (!(m_active && m_k == RISE_K)) timeout("wait_high");
    endtask

    task automatic accept2(input logic [15:0] s);
        bit ok;
        ok         = 1'b0;
        in_valid2  = 1'b1;
        in_sample2 = s;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready2;
        end
        if (!ok) timeout("accept2");
        @(posedge clk);
        #1;
    endtask

    logic [31:0] lit_exp[5] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000,
                                32'h46FF_FE00, 32'hC700_0000};

    initial begin
        int base;
        int n;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", data, 32'h0);
        chk("rst_dataIn", dataIn, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        #3 rstn = 1'b1;

        // FRAC_BITS=15 instance
        accept2(16'sd16384);
        accept2(-16'sd1);
        in_valid2 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        if (q2.size() >= 2) begin
            chk("frac_16384", q2[0], 32'h3F00_0000);
            chk("frac_m1", q2[1], 32'hB800_0000);
        end else timeout("frac_strobes");

        // Back-to-back literals with in_valid held high
        base = q1.size();
        send(16'sd1);
        send(-16'sd1);
        send(16'sd0);
        send(16'sd32767);
        send(-16'sd32768);
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        if (q1.size() >= base + 5) begin
            for (int j = 0; j < 5; j++) chk("literal", q1[base + j], lit_exp[j]);
        end else timeout("literal_strobes");

        for (int j = 0; j < 100; j++) send(16'($urandom));
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Backpressure: a pulse during HIGH must be ignored
        send(16'sd1234);
        in_valid = 1'b0;
        wait_high();
        in_valid  = 1'b1;
        in_sample = -16'sd555;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = q1.size();
        repeat (10) @(posedge clk);
        #1;
        chk("bp_no_strobe", q1.size(), n);
        send(-16'sd555);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("bp_resent", q1[$], 32'hC40A_C000);

        // Asynchronous reset while dataIn is high
        send(16'sd100);
        in_valid = 1'b0;
        wait_high();
        #2 rstn = 1'b0;
        #1;
        chk("midrst_dataIn", dataIn, 0);
        chk("midrst_data", data, 32'h0);
        chk("midrst_cnt", sample_cnt, 0);
        chk("midrst_ready", in_ready, 0);
        @(posedge clk);
        #4 rstn = 1'b1;
        send(16'sd7);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst", q1[$], 32'h40E0_0000);

        // Window: 28 more strobes gives 29 since reset
        for (int j = 0; j < 28; j++) send(16'($urandom));
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("final_cnt", sample_cnt, 1);
        chk("final_full", window_full, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sample_to_float_feeder.md
Name: sample_to_float_feeder

Overview:
- Upstream stage of the 28-deep float history window.
- Accepts signed fixed-point ADC samples over a valid/ready handshake and converts each one exactly to IEEE754 single precision.
- Presents the result on `data`, then generates a clean `dataIn` rising-edge strobe, with `data` guaranteed stable before, during and after that edge.
- Also tracks how many samples have been issued so downstream DFT logic knows when the window is first full.

Parameters:
- IN_W, 16: input sample width, signed two's complement. Legal range 2..24, so conversion is always exact.
- FRAC_BITS, 0: binary point position. Value = in_sample * 2^-FRAC_BITS. Legal range 0..30.
- SETUP, 1: cycles `data` is stable before `dataIn` rises. Must be >=1.
- STROBE_HI, 2: cycles `dataIn` is held high. Must be >=1.
- STROBE_LO, 2: cycles `dataIn` is held low after the high phase before the next sample is accepted. Must be >=1.
- SIZE, 28: history window depth, used for `sample_cnt` and `window_full`.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset. 0 = reset, 1 = normal.
- in_valid  in  1  `in_sample` is valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_sample  in  IN_W  signed fixed-point sample.
- data  out  32  IEEE754 single of the latest accepted sample.
- dataIn  out  1  strobe; its rising edge marks `data` ready.
- busy  out  1  high in any state other than IDLE.
- sample_cnt  out  $clog2(SIZE)  strobes issued modulo SIZE.
- window_full  out  1  sticky; set once SIZE strobes have been issued since reset.

Behaviour:
- Reset (async, rstn=0): data=32'h0, dataIn=0, busy=0, in_ready=0 while rstn=0, sample_cnt=0, window_full=0, state=IDLE.
  - Reset mid-strobe forces dataIn low immediately; no further edge is generated.
  - First cycle after release: in_ready=1.
- FSM states: IDLE, CONV, SETUP, HIGH, LOW.
  - IDLE: in_ready=1. On in_valid&in_ready at edge T0, capture sample, go to CONV.
  - CONV: 1 cycle. Registered converter output loads `data` at edge T1. Go to SETUP.
  - SETUP: SETUP cycles, dataIn=0. Then go to HIGH.
  - HIGH: dataIn=1 for STROBE_HI cycles. Rising edge of dataIn at edge T1+SETUP. On the rising-edge cycle, sample_cnt increments mod SIZE; window_full is set when the count reaches SIZE total strobes.
  - LOW: dataIn=0 for STROBE_LO cycles. Then go to IDLE.
- Throughput: one sample per 2+SETUP+STROBE_HI+STROBE_LO cycles (7 with defaults). in_ready=0 outside IDLE; in_valid is ignored there and the sample is not consumed.
- `data` changes only at the CONV→SETUP edge. It is never modified while dataIn=1 or in the SETUP/LOW phases.
- Conversion rules:
  - sign = msb.
  - mag = |sample| in IN_W-bit unsigned, so -2^(IN_W-1) maps to 2^(IN_W-1) with no overflow.
  - p = index of leading one of mag.
  - exp = 127 + p - FRAC_BITS.
  - mantissa = mag bits below p, left-aligned into 23 bits, zero-filled.
  - No rounding, subnormals or infinities are possible within the legal parameter ranges.
  - Zero input gives +0 (32'h00000000), never -0.
- sample_cnt wraps SIZE-1 → 0. window_full never clears except on reset.

Decomposition:
- Shared package `fp32_pkg` holds:
  - FP32_BIAS=127, FP32_EXP_W=8, FP32_MAN_W=23.
  - FP32_ZERO constant.
  - fp32_t packed struct {sign, exp, man}.
  - feeder_state_t enum {IDLE, CONV, SETUP, HIGH, LOW}.
- Sub-module `int_to_fp32`: purely combinational signed fixed-point to fp32 converter (priority encoder, barrel shift, exponent add), parameterised by IN_W and FRAC_BITS. It is reusable by other front ends.
- The FSM, counters and output registers stay in the top module.

Test Plan:
- Defaults; samples 1, -1, 0 back-to-back with in_valid held high → data = 3F800000, BF800000, 00000000. Accepts occur 7 cycles apart; dataIn rises 2 cycles after each accept and is high for exactly 2 cycles.
- Extremes with IN_W=16: 32767 → 46FFFE00; -32768 → C7000000. With FRAC_BITS=15: 16384 → 3F000000; -1 → B8000000.
- Stability check: assert `data` is unchanged from 1 cycle before dataIn rises until dataIn falls, across 100 random samples. Compare every value against a reference real-to-bits model.
- Backpressure: in_valid pulsed for 1 cycle during HIGH → not accepted, no strobe, `data` unchanged. The same sample is accepted when re-presented in IDLE.
- Reset mid-HIGH: rstn=0 asynchronously → dataIn=0 and data=0 within the same cycle, sample_cnt=0. After release in_ready=1; the next sample produces a normal strobe.
- Window count: issue 28 samples → window_full=0 after the 27th strobe, 1 on the 28th rising edge with sample_cnt=0. After the 29th, sample_cnt=1 and window_full stays 1.
